// File: rtl/bcd_counter_ndigit.sv
// N-digit packed-BCD up/down counter with load, wrap/saturate policy and boundary flags.
// Optional binary mirror output counter_bin is enabled by defining BCD_COUNTER_BIN_OUT_EN.
module bcd_counter_ndigit #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                  counter_clk_signal,
    input  logic                  reset,
    input  logic                  switch,
    input  logic                  step,
    input  logic                  dir,
    input  logic                  sat_mode,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   counter_bcd,
    output logic                  rollover,
    output logic                  at_max,
`ifdef BCD_COUNTER_BIN_OUT_EN
    output logic                  at_zero,
    output logic [BIN_W-1:0]      counter_bin
`else
    output logic                  at_zero
`endif
);

    localparam int unsigned W = 4 * DIGITS;
    localparam logic [W-1:0] AllNines = {DIGITS{4'h9}};

    function automatic longint unsigned pow10(int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    if ((64'd1 << BIN_W) < pow10(DIGITS)) begin : gen_bin_w_check
        $error("BIN_W too narrow to hold 10^DIGITS - 1");
    end

    logic [W-1:0] bcd_q, bcd_d;
    logic [W-1:0] inc_val, dec_val, load_san;
    logic         roll_q, roll_d;
    logic         carry, borrow;
    logic [3:0]   dig;
    logic         count_en;
    logic         at_bound;

    // Ripple carry/borrow across digits within one cycle; load nibbles above 9 clamp to 9.
    always_comb begin
        inc_val  = bcd_q;
        dec_val  = bcd_q;
        load_san = load_value;
        carry    = 1'b1;
        borrow   = 1'b1;
        dig      = 4'd0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig = bcd_q[4*i +: 4];
            if (carry) begin
                inc_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
            end
            if (borrow) begin
                dec_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            end
            carry  = carry & (dig == 4'd9);
            borrow = borrow & (dig == 4'd0);
            if (load_value[4*i +: 4] > 4'd9) begin
                load_san[4*i +: 4] = 4'd9;
            end
        end
    end

    assign at_max   = (bcd_q == AllNines);
    assign at_zero  = (bcd_q == '0);
    assign count_en = switch & step;
    assign at_bound = dir ? at_max : at_zero;

    always_comb begin
        bcd_d  = bcd_q;
        roll_d = 1'b0;
        if (load) begin
            bcd_d = load_san;
        end else if (count_en) begin
            if (at_bound) begin
                if (!sat_mode) begin
                    bcd_d  = dir ? '0 : AllNines;
                    roll_d = 1'b1;
                end
            end else begin
                bcd_d = dir ? inc_val : dec_val;
            end
        end
    end

    always_ff @(posedge counter_clk_signal) begin
        if (reset) begin
            bcd_q  <= '0;
            roll_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            roll_q <= roll_d;
        end
    end

    assign counter_bcd = bcd_q;
    assign rollover    = roll_q;

`ifdef BCD_COUNTER_BIN_OUT_EN
    localparam logic [BIN_W-1:0] MaxBin = BIN_W'(pow10(DIGITS) - 1);

    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BIN_W-1:0] load_bin, weight;

    // Weighted digit sum of the sanitised load so the mirror lands in the load cycle.
    always_comb begin
        load_bin = '0;
        weight   = BIN_W'(1);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            load_bin = load_bin + BIN_W'(load_san[4*i +: 4]) * weight;
            weight   = weight * BIN_W'(10);
        end
    end

    always_comb begin
        bin_d = bin_q;
        if (load) begin
            bin_d = load_bin;
        end else if (count_en) begin
            if (at_bound) begin
                if (!sat_mode) begin
                    bin_d = dir ? '0 : MaxBin;
                end
            end else begin
                bin_d = dir ? bin_q + BIN_W'(1) : bin_q - BIN_W'(1);
            end
        end
    end

    always_ff @(posedge counter_clk_signal) begin
        if (reset) begin
            bin_q <= '0;
        end else begin
            bin_q <= bin_d;
        end
    end

    assign counter_bin = bin_q;
`endif

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Self-checking bench for bcd_counter_ndigit: directed vector table, hand sequences and a
// randomized soak against a decimal reference model.
module tb_bcd_counter_ndigit;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned BIN_W  = 14;
    localparam int unsigned W      = 4 * DIGITS;
    localparam int          MAXV   = 9999;

    logic          clk = 1'b0;
    logic          reset, switch, step, dir, sat_mode, load;
    logic [W-1:0]  load_value;
    logic [W-1:0]  counter_bcd;
    logic          rollover, at_max, at_zero;
`ifdef BCD_COUNTER_BIN_OUT_EN
    logic [BIN_W-1:0] counter_bin;
`endif

    int   checks = 0;
    int   errors = 0;
    int   model_val = 0;
    logic model_roll = 1'b0;

    bcd_counter_ndigit #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .counter_clk_signal (clk),
        .reset              (reset),
        .switch             (switch),
        .step               (step),
        .dir                (dir),
        .sat_mode           (sat_mode),
        .load               (load),
        .load_value         (load_value),
        .counter_bcd        (counter_bcd),
        .rollover           (rollover),
        .at_max             (at_max),
`ifdef BCD_COUNTER_BIN_OUT_EN
        .at_zero            (at_zero),
        .counter_bin        (counter_bin)
`else
        .at_zero            (at_zero)
`endif
    );

    always #5 clk = ~clk;

    // Decimal value of a packed BCD word, nibbles above 9 read as 9.
    function automatic int bcd_to_int(logic [W-1:0] b);
        int v;
        int d;
        v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic digits_ok(logic [W-1:0] b);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step_model();
        if (reset) begin
            model_val  = 0;
            model_roll = 1'b0;
        end else if (load) begin
            model_val  = bcd_to_int(load_value);
            model_roll = 1'b0;
        end else if (switch && step) begin
            model_roll = 1'b0;
            if (dir) begin
                if (model_val == MAXV) begin
                    if (!sat_mode) begin
                        model_val  = 0;
                        model_roll = 1'b1;
                    end
                end else begin
                    model_val = model_val + 1;
                end
            end else begin
                if (model_val == 0) begin
                    if (!sat_mode) begin
                        model_val  = MAXV;
                        model_roll = 1'b1;
                    end
                end else begin
                    model_val = model_val - 1;
                end
            end
        end else begin
            model_roll = 1'b0;
        end
    endtask

    task automatic cycle();
        step_model();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic sw, input logic st, input logic d,
                          input logic s, input logic l, input logic [W-1:0] lv);
        reset = r; switch = sw; step = st; dir = d; sat_mode = s; load = l; load_value = lv;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_bcd"}, 32'(counter_bcd), 32'(int_to_bcd(model_val)));
        check({tag, "_roll"}, 32'(rollover), 32'(model_roll));
        check({tag, "_max"}, 32'(at_max), 32'(model_val == MAXV));
        check({tag, "_zero"}, 32'(at_zero), 32'(model_val == 0));
        check({tag, "_digits"}, 32'(digits_ok(counter_bcd)), 32'd1);
`ifdef BCD_COUNTER_BIN_OUT_EN
        check({tag, "_bin"}, 32'(counter_bin), 32'(model_val));
`endif
    endtask

    typedef struct {
        logic         rst;
        logic         sw;
        logic         st;
        logic         dr;
        logic         sat;
        logic         ld;
        logic [W-1:0] lv;
        logic [W-1:0] exp_bcd;
        logic         exp_roll;
    } vec_t;

    vec_t vecs[$];
    logic [W-1:0] seq_exp[7];

    initial begin
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

        // rst sw st dir sat ld load_value exp_bcd roll
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h9998, 16'h9998, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1000, 16'h1000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0999, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h9999, 16'h9999, 1'b0});
        for (int k = 0; k < 3; k++)
            vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h9999, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0});
        for (int k = 0; k < 3; k++)
            vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h12F4, 16'h1294, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0500, 16'h0500, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4321, 16'h0000, 1'b0});

        foreach (vecs[i]) begin
            set_in(vecs[i].rst, vecs[i].sw, vecs[i].st, vecs[i].dr, vecs[i].sat, vecs[i].ld,
                   vecs[i].lv);
            cycle();
            check($sformatf("vec%0d_bcd", i), 32'(counter_bcd), 32'(vecs[i].exp_bcd));
            check($sformatf("vec%0d_roll", i), 32'(rollover), 32'(vecs[i].exp_roll));
            check($sformatf("vec%0d_max", i), 32'(at_max), 32'(vecs[i].exp_bcd == 16'h9999));
            check($sformatf("vec%0d_zero", i), 32'(at_zero), 32'(vecs[i].exp_bcd == 16'h0000));
`ifdef BCD_COUNTER_BIN_OUT_EN
            check($sformatf("vec%0d_bin", i), 32'(counter_bin),
                  32'(bcd_to_int(vecs[i].exp_bcd)));
`endif
        end

        // Step held high counts every clock, with a direction flip mid-run.
        seq_exp = '{16'h0998, 16'h0999, 16'h1000, 16'h1001, 16'h1002, 16'h1001, 16'h1000};
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0997);
        cycle();
        check("seq_load", 32'(counter_bcd), 32'h0997);
        for (int k = 0; k < 7; k++) begin
            set_in(1'b0, 1'b1, 1'b1, (k < 5), 1'b0, 1'b0, '0);
            cycle();
            check($sformatf("seq%0d_bcd", k), 32'(counter_bcd), 32'(seq_exp[k]));
            check($sformatf("seq%0d_roll", k), 32'(rollover), 32'd0);
        end

        // Random soak against the decimal model.
        for (int n = 0; n < 10000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            load     = ($urandom_range(0, 15) == 0);
            switch   = ($urandom_range(0, 3) != 0);
            step     = ($urandom_range(0, 3) != 0);
            dir      = 1'($urandom_range(0, 1));
            sat_mode = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       load_value = 16'h9999;
                1:       load_value = 16'h0000;
                2:       load_value = 16'h9998;
                3:       load_value = 16'h0001;
                default: load_value = 16'($urandom);
            endcase
            cycle();
            check_model($sformatf("soak%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
